// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 bus responder: opcodes, FSM states,
// character constants and the address-counter stepping rule.
package lcd_pkg;

    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_ENTRY   = 8'h04;
    localparam logic [7:0] CMD_DISPLAY = 8'h08;
    localparam logic [7:0] CMD_SHIFT   = 8'h10;
    localparam logic [7:0] CMD_FUNC    = 8'h20;
    localparam logic [7:0] CMD_CGRAM   = 8'h40;
    localparam logic [7:0] CMD_DDRAM   = 8'h80;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_ZERO  = 8'h30;
    localparam logic [7:0] CHAR_SLASH = 8'h2F;
    localparam logic [7:0] CHAR_COLON = 8'h3A;

    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam logic [6:0] LINE_LAST  = 7'h27;
    localparam logic [6:0] ONE_LINE_LAST = 7'h4F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_BUSY
    } lcd_state_t;

    // Step the address counter, wrapping at the ends of the active line map.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc,
                                           input logic two_line);
        logic [6:0] nxt;
        nxt = inc ? ac + 7'd1 : ac - 7'd1;
        if (two_line) begin
            if (inc && ac == LINE0_BASE + LINE_LAST)       nxt = LINE1_BASE;
            else if (inc && ac == LINE1_BASE + LINE_LAST)  nxt = LINE0_BASE;
            else if (!inc && ac == LINE0_BASE)             nxt = LINE1_BASE + LINE_LAST;
            else if (!inc && ac == LINE1_BASE)             nxt = LINE0_BASE + LINE_LAST;
        end else begin
            if (inc && ac == ONE_LINE_LAST)                nxt = LINE0_BASE;
            else if (!inc && ac == LINE0_BASE)             nxt = ONE_LINE_LAST;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 2 lines x 16 columns display memory: one write port, a single-cycle
// fill-with-space, and a combinational read port.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [7:0] wdata,
    input  logic       fill,
    input  logic [4:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem_q [32];
    logic [7:0] mem_d [32];

    always_comb begin
        mem_d = mem_q;
        if (fill) begin
            for (int unsigned i = 0; i < 32; i++) mem_d[i] = CHAR_SPACE;
        end else if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 32; i++) mem_q[i] <= CHAR_SPACE;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/lcd_bus_responder.sv
// Passive HD44780 model: samples the LCD bus, decodes instructions and data
// writes, tracks busy time and exposes the display memory for readback.
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int unsigned BUSY_CYC = 3700,
    parameter int unsigned CLR_CYC  = 152000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    input  logic       rd_line,
    input  logic [3:0] rd_col,
    output logic [7:0] rd_char,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_id,
    output logic       entry_sh,
    output logic       func_8bit,
    output logic       func_2line,
    output logic       busy,
    output logic       err_busy,
    output logic       err_rw,
    output logic       cmd_stb,
    output logic [7:0] cmd_byte
);

    logic       e_s1_q, e_s2_q, e_s3_q, rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q;
    logic [7:0] data_s1_q, data_s2_q;
    lcd_state_t state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic       x_rs_q, x_rs_d;
    logic [7:0] x_data_q, x_data_d;
    logic [6:0] ac_q, ac_d;
    logic       disp_on_q, disp_on_d, cursor_on_q, cursor_on_d, blink_on_q, blink_on_d;
    logic       entry_id_q, entry_id_d, entry_sh_q, entry_sh_d;
    logic       func_8bit_q, func_8bit_d, func_2line_q, func_2line_d;
    logic       busy_q, busy_d, err_busy_q, err_busy_d, err_rw_q, err_rw_d;
    logic       cmd_stb_q, cmd_stb_d;
    logic [7:0] cmd_byte_q, cmd_byte_d;
    logic       fall, mem_we, mem_fill, is_long;

    // e_s3_q holds the previous synchronised strobe for edge detection.
    assign fall = e_s3_q & ~e_s2_q;
    assign is_long = !x_rs_q && (x_data_q == CMD_CLEAR || x_data_q[7:1] == CMD_HOME[7:1]);

    always_comb begin
        state_d = state_q;      cnt_d = cnt_q;
        x_rs_d = x_rs_q;        x_data_d = x_data_q;
        ac_d = ac_q;
        disp_on_d = disp_on_q;  cursor_on_d = cursor_on_q;  blink_on_d = blink_on_q;
        entry_id_d = entry_id_q; entry_sh_d = entry_sh_q;
        func_8bit_d = func_8bit_q; func_2line_d = func_2line_q;
        busy_d = busy_q;        err_busy_d = err_busy_q;    err_rw_d = err_rw_q;
        cmd_stb_d = 1'b0;       cmd_byte_d = cmd_byte_q;
        mem_we = 1'b0;          mem_fill = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    if (rw_s2_q) begin
                        err_rw_d = 1'b1;
                    end else begin
                        state_d = ST_EXEC;
                        busy_d = 1'b1;
                        x_rs_d = rs_s2_q;
                        x_data_d = data_s2_q;
                        if (!rs_s2_q) begin
                            cmd_stb_d = 1'b1;
                            cmd_byte_d = data_s2_q;
                        end
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_BUSY;
                cnt_d = is_long ? 32'(CLR_CYC - 1) : 32'(BUSY_CYC - 1);
                if (x_rs_q) begin
                    mem_we = (ac_q[5:4] == 2'b00);
                    ac_d = ac_step(ac_q, entry_id_q, func_2line_q);
                end else if ((x_data_q & CMD_DDRAM) != '0) begin
                    ac_d = x_data_q[6:0];
                end else if ((x_data_q & CMD_CGRAM) != '0) begin
                    ac_d = ac_q;
                end else if ((x_data_q & CMD_FUNC) != '0) begin
                    func_8bit_d = x_data_q[4];
                    func_2line_d = x_data_q[3];
                end else if ((x_data_q & CMD_SHIFT) != '0) begin
                    ac_d = ac_q;
                end else if ((x_data_q & CMD_DISPLAY) != '0) begin
                    disp_on_d = x_data_q[2];
                    cursor_on_d = x_data_q[1];
                    blink_on_d = x_data_q[0];
                end else if ((x_data_q & CMD_ENTRY) != '0) begin
                    entry_id_d = x_data_q[1];
                    entry_sh_d = x_data_q[0];
                end else if ((x_data_q & CMD_HOME) != '0) begin
                    ac_d = LINE0_BASE;
                end else if (x_data_q == CMD_CLEAR) begin
                    mem_fill = 1'b1;
                    ac_d = LINE0_BASE;
                    entry_id_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (fall && state_q != ST_IDLE) err_busy_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_s1_q <= 1'b0; e_s2_q <= 1'b0; e_s3_q <= 1'b0;
            rs_s1_q <= 1'b0; rs_s2_q <= 1'b0; rw_s1_q <= 1'b0; rw_s2_q <= 1'b0;
            data_s1_q <= '0; data_s2_q <= '0;
            state_q <= ST_IDLE; cnt_q <= '0;
            x_rs_q <= 1'b0; x_data_q <= '0;
            ac_q <= '0;
            disp_on_q <= 1'b0; cursor_on_q <= 1'b0; blink_on_q <= 1'b0;
            entry_id_q <= 1'b1; entry_sh_q <= 1'b0;
            func_8bit_q <= 1'b1; func_2line_q <= 1'b0;
            busy_q <= 1'b0; err_busy_q <= 1'b0; err_rw_q <= 1'b0;
            cmd_stb_q <= 1'b0; cmd_byte_q <= '0;
        end else begin
            e_s1_q <= lcd_e; e_s2_q <= e_s1_q; e_s3_q <= e_s2_q;
            rs_s1_q <= lcd_rs; rs_s2_q <= rs_s1_q;
            rw_s1_q <= lcd_rw; rw_s2_q <= rw_s1_q;
            data_s1_q <= lcd_data; data_s2_q <= data_s1_q;
            state_q <= state_d; cnt_q <= cnt_d;
            x_rs_q <= x_rs_d; x_data_q <= x_data_d;
            ac_q <= ac_d;
            disp_on_q <= disp_on_d; cursor_on_q <= cursor_on_d; blink_on_q <= blink_on_d;
            entry_id_q <= entry_id_d; entry_sh_q <= entry_sh_d;
            func_8bit_q <= func_8bit_d; func_2line_q <= func_2line_d;
            busy_q <= busy_d; err_busy_q <= err_busy_d; err_rw_q <= err_rw_d;
            cmd_stb_q <= cmd_stb_d; cmd_byte_q <= cmd_byte_d;
        end
    end

    lcd_ddram u_ddram (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr ({ac_q[6], ac_q[3:0]}),
        .wdata (x_data_q),
        .fill  (mem_fill),
        .raddr ({rd_line, rd_col}),
        .rdata (rd_char)
    );

    assign ac = ac_q;
    assign disp_on = disp_on_q;
    assign cursor_on = cursor_on_q;
    assign blink_on = blink_on_q;
    assign entry_id = entry_id_q;
    assign entry_sh = entry_sh_q;
    assign func_8bit = func_8bit_q;
    assign func_2line = func_2line_q;
    assign busy = busy_q;
    assign err_busy = err_busy_q;
    assign err_rw = err_rw_q;
    assign cmd_stb = cmd_stb_q;
    assign cmd_byte = cmd_byte_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder with shortened busy times; accepted
// instruction bytes are checked against a queue of expected cmd_byte values.
module tb_lcd_bus_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [7:0] lcd_data = '0;
    logic       rd_line = 1'b0;
    logic [3:0] rd_col = '0;
    logic [7:0] rd_char, cmd_byte;
    logic [6:0] ac;
    logic       disp_on, cursor_on, blink_on, entry_id, entry_sh, func_8bit, func_2line;
    logic       busy, err_busy, err_rw, cmd_stb;

    int checks = 0;
    int errors = 0;
    int stb_count = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;
    logic [7:0] date_s [10] = '{8'h32, 8'h30, 8'h32, 8'h34, 8'h2F, 8'h30, 8'h31, 8'h2F, 8'h30, 8'h31};
    logic [7:0] time_s [8]  = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h35};

    lcd_bus_responder #(.BUSY_CYC(40), .CLR_CYC(200)) dut (
        .clk(clk), .reset(reset), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data), .rd_line(rd_line), .rd_col(rd_col), .rd_char(rd_char),
        .ac(ac), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .entry_id(entry_id), .entry_sh(entry_sh), .func_8bit(func_8bit),
        .func_2line(func_2line), .busy(busy), .err_busy(err_busy), .err_rw(err_rw),
        .cmd_stb(cmd_stb), .cmd_byte(cmd_byte)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmd_stb === 1'b1) begin
            stb_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL cmd_stb_unexpected observed=0x%0h expected=none", cmd_byte);
            end else begin
                exp_b = exp_q.pop_front();
                assert (cmd_byte === exp_b) else begin
                    errors++;
                    $error("FAIL cmd_byte observed=0x%0h expected=0x%0h", cmd_byte, exp_b);
                end
            end
        end
    end

    task automatic bus_xfer(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic instr(input logic [7:0] d);
        exp_q.push_back(d);
        bus_xfer(1'b0, 1'b0, d);
        wait_idle();
    endtask

    task automatic read_cell(input string tag, input logic line, input logic [3:0] col,
                             input logic [7:0] exp);
        rd_line = line; rd_col = col;
        #1;
        check(tag, {24'd0, rd_char}, {24'd0, exp});
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("rst_ac", {25'd0, ac}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_entry_id", {31'd0, entry_id}, 32'd1);
        check("rst_func_8bit", {31'd0, func_8bit}, 32'd1);
        check("rst_func_2line", {31'd0, func_2line}, 32'd0);
        check("rst_disp_on", {31'd0, disp_on}, 32'd0);
        check("rst_cmd_byte", {24'd0, cmd_byte}, 32'h0);
        read_cell("rst_cell", 1'b1, 4'd15, 8'h20);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Power-up instruction sequence
        instr(8'h01); instr(8'h38); instr(8'h06); instr(8'h0C);
        check("init_func_2line", {31'd0, func_2line}, 32'd1);
        check("init_func_8bit", {31'd0, func_8bit}, 32'd1);
        check("init_entry_id", {31'd0, entry_id}, 32'd1);
        check("init_disp_on", {31'd0, disp_on}, 32'd1);
        check("init_cursor_on", {31'd0, cursor_on}, 32'd0);
        check("init_stb_count", stb_count, 32'd4);
        check("init_err_busy", {31'd0, err_busy}, 32'd0);

        // Latency: the change lands on the 3rd edge after the first low sample
        exp_q.push_back(8'h0F);
        @(negedge clk);
        lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h0F; lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        check("lat_cursor_before", {31'd0, cursor_on}, 32'd0);
        check("lat_busy_exec", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check("lat_cursor_after", {31'd0, cursor_on}, 32'd1);
        wait_idle();

        // Date on line 0
        instr(8'h80);
        foreach (date_s[i]) begin bus_xfer(1'b1, 1'b0, date_s[i]); wait_idle(); end
        foreach (date_s[i]) read_cell("date_cell", 1'b0, 4'(i), date_s[i]);
        check("date_ac", {25'd0, ac}, 32'h0A);

        // Time on line 1, then clear
        instr(8'hC0);
        foreach (time_s[i]) begin bus_xfer(1'b1, 1'b0, time_s[i]); wait_idle(); end
        foreach (time_s[i]) read_cell("time_cell", 1'b1, 4'(i), time_s[i]);
        check("time_ac", {25'd0, ac}, 32'h48);
        instr(8'h01);
        for (int i = 0; i < 32; i++) read_cell("clear_cell", 1'(i / 16), 4'(i % 16), 8'h20);
        check("clear_ac", {25'd0, ac}, 32'h0);

        // Decrement wrap 0x00 -> 0x67 in two-line mode
        instr(8'h04);
        bus_xfer(1'b1, 1'b0, 8'h41); wait_idle();
        check("dec_wrap_ac", {25'd0, ac}, 32'h67);
        read_cell("dec_wrap_cell", 1'b0, 4'd0, 8'h41);
        instr(8'h06);

        // Off-screen write, then 0x27 -> 0x40 wrap
        instr(8'hA7);
        check("a7_ac", {25'd0, ac}, 32'h27);
        bus_xfer(1'b1, 1'b0, 8'h58); wait_idle();
        check("wrap_ac_40", {25'd0, ac}, 32'h40);
        read_cell("offscreen_not_stored", 1'b0, 4'd7, 8'h20);
        bus_xfer(1'b1, 1'b0, 8'h59); wait_idle();
        read_cell("wrap_stored", 1'b1, 4'd0, 8'h59);
        check("wrap_ac_41", {25'd0, ac}, 32'h41);

        // Strobe while busy is dropped; read cycle is rejected
        exp_q.push_back(8'h85);
        bus_xfer(1'b0, 1'b0, 8'h85);
        bus_xfer(1'b0, 1'b0, 8'h80);
        check("err_busy_set", {31'd0, err_busy}, 32'd1);
        wait_idle();
        check("dropped_ac", {25'd0, ac}, 32'h05);
        bus_xfer(1'b0, 1'b1, 8'h80);
        check("err_rw_set", {31'd0, err_rw}, 32'd1);
        check("rw_busy", {31'd0, busy}, 32'd0);
        check("rw_ac", {25'd0, ac}, 32'h05);
        check("err_busy_sticky", {31'd0, err_busy}, 32'd1);

        // One-line wrap 0x4F -> 0x00
        instr(8'h30);
        instr(8'hCF);
        bus_xfer(1'b1, 1'b0, 8'h5A); wait_idle();
        check("one_line_wrap_ac", {25'd0, ac}, 32'h0);

        // Reset in the middle of a clear's busy period
        instr(8'h38);
        exp_q.push_back(8'h01);
        bus_xfer(1'b0, 1'b0, 8'h01);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_func_2line", {31'd0, func_2line}, 32'd0);
        check("mid_rst_err_busy", {31'd0, err_busy}, 32'd0);
        check("mid_rst_err_rw", {31'd0, err_rw}, 32'd0);
        check("mid_rst_disp_on", {31'd0, disp_on}, 32'd0);
        check("mid_rst_cmd_byte", {24'd0, cmd_byte}, 32'h0);
        read_cell("mid_rst_cell", 1'b1, 4'd0, 8'h20);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        lcd_data = '0;
        repeat (3) @(negedge clk);
        instr(8'h38);
        check("post_rst_func_2line", {31'd0, func_2line}, 32'd1);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lcd_bus_responder.md
LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

Interface
REQ-001 SHALL have parameter BUSY_CYC, default 3700, giving the busy time after a normal instruction or data write (37 us at 100 MHz).
REQ-002 SHALL have parameter CLR_CYC, default 152000, giving the busy time after clear display or return home (1.52 ms at 100 MHz).
REQ-003 SHALL have port clk, input, 1 bit: system clock.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports lcd_e, lcd_rs and lcd_rw, input, 1 bit each: HD44780 bus strobe, register select and read/write.
REQ-006 SHALL have port lcd_data, input, 8 bits: HD44780 bus data.
REQ-007 SHALL have ports rd_line (input, 1 bit) and rd_col (input, 4 bits): the display-memory read address.
REQ-008 SHALL have port rd_char, output, 8 bits: the stored character at the read address.
REQ-009 SHALL have port ac, output, 7 bits: the address counter.
REQ-010 SHALL have ports disp_on, cursor_on, blink_on, entry_id, entry_sh, func_8bit and func_2line, output, 1 bit each: the decoded mode flags.
REQ-011 SHALL have ports busy, err_busy and err_rw, output, 1 bit each: the busy status and two sticky error flags.
REQ-012 SHALL have ports cmd_stb (output, 1 bit) and cmd_byte (output, 8 bits): a one-cycle pulse, plus the byte of each accepted instruction.

Function
REQ-013 SHALL synchronise lcd_e, lcd_rs, lcd_rw and lcd_data through 2 flip-flop stages each.
REQ-014 SHALL detect a transfer on the falling edge of the synchronised lcd_e, using the rs, rw and data values from the same synchronised sample.
REQ-015 SHALL make the state change of a transfer visible at the outputs exactly 3 clk cycles after the first clk edge that samples lcd_e low.
REQ-016 SHALL implement the FSM states IDLE, EXEC and BUSY:
- IDLE goes to EXEC on a detected falling edge.
- EXEC lasts 1 cycle, then goes to BUSY.
- BUSY counts down CLR_CYC (for 0x01 and 0x02/0x03) or BUSY_CYC (for all other transfers), then goes to IDLE.
REQ-017 SHALL drive busy high exactly while the FSM is in EXEC or BUSY.
REQ-018 SHALL discard a falling edge that arrives during EXEC or BUSY and set err_busy, without changing any state.
REQ-019 SHALL discard a transfer with rw=1 and set err_rw; the FSM stays in IDLE.
REQ-020 SHALL decode instructions (rs=0) by highest set bit:
- 0x01: fill all 32 cells with 0x20, set ac=0 and entry_id=1.
- 0x02/0x03: set ac=0.
- 0x04-0x07: set entry_id=bit1 and entry_sh=bit0.
- 0x08-0x0F: set disp_on=bit2, cursor_on=bit1 and blink_on=bit0.
- 0x10-0x1F: no state change.
- 0x20-0x3F: set func_8bit=bit4 and func_2line=bit3.
- 0x40-0x7F (CGRAM address): no state change.
- 0x80-0xFF: set ac=data[6:0].
- 0x00: no operation, but still busy for BUSY_CYC.
REQ-021 SHALL pulse cmd_stb for 1 cycle in EXEC for every accepted instruction, with cmd_byte holding the instruction byte; data writes (rs=1) do not pulse cmd_stb.
REQ-022 SHALL handle a data write (rs=1) as follows: store the byte at (line=ac[6], col=ac[3:0]) only when ac[5:4]==0, then step ac.
REQ-023 SHALL step ac by +1 when entry_id=1 and by -1 when entry_id=0.
REQ-024 SHALL apply these wrap rules to ac steps when func_2line=1: 0x27+1 gives 0x40; 0x67+1 gives 0x00; 0x00-1 gives 0x67; 0x40-1 gives 0x27.
REQ-025 SHALL apply these wrap rules to ac steps when func_2line=0: 0x4F+1 gives 0x00; 0x00-1 gives 0x4F.
REQ-026 SHALL leave ac unconstrained by the wrap rules when it is set directly by an 0x80-0xFF instruction; the wrap rules apply only to steps.
REQ-027 SHALL produce rd_char combinationally from the cell array at {rd_line, rd_col}.
REQ-028 SHALL give priority to the clear fill when a read and a clear occur in the same cycle; rd_char shows 0x20 from the next cycle.

Reset
REQ-029 SHALL, while reset is low, force these values:
- All cells: 0x20.
- ac=0.
- disp_on, cursor_on, blink_on, entry_sh and func_2line: 0.
- entry_id=1 and func_8bit=1.
- busy, err_busy, err_rw and cmd_stb: 0; cmd_byte=0.
- FSM in IDLE with the busy counter at 0; synchroniser flops cleared to 0.
REQ-030 SHALL abandon any EXEC or BUSY operation when reset is asserted mid-operation, with no partial write.
REQ-031 SHALL clear err_busy and err_rw only by reset.

Structure
REQ-032 SHALL take from shared package lcd_pkg: the instruction opcode constants, the FSM state typedef, the character constants (0x20, 0x30, 0x2F, 0x3A) and the line base addresses 0x00/0x40.
REQ-033 SHALL contain one sub-module, lcd_ddram: a 2x16x8 flop array with a write port, a 1-cycle fill-with-0x20 input and a combinational read port.

Verification
REQ-034 SHALL include this scenario: reset release, then 0x01, 0x38, 0x06, 0x0C at 4 ms spacing -> func_2line=1, func_8bit=1, entry_id=1, disp_on=1, cursor_on=0, with 4 cmd_stb pulses, cmd_byte values in order 0x01, 0x38, 0x06, 0x0C, and err_busy=0.
REQ-035 SHALL include this scenario: 0x80, then data "2024/01/01" -> cells line0 col0-9 read back 0x32,0x30,0x32,0x34,0x2F,0x30,0x31,0x2F,0x30,0x31, and ac=0x0A.
REQ-036 SHALL include this scenario: 0xC0, then "00:00:05" -> line1 col0-7 hold those characters and ac=0x48; then 0x01 -> all 32 cells read 0x20 and ac=0.
REQ-037 SHALL include this scenario: func_2line=1, 0xA7, 2 data writes -> first write not stored (ac=0x27), and ac ends at 0x41 after 0x27 wraps to 0x40.
REQ-038 SHALL include this scenario: 2 E pulses 1 us apart -> second dropped, err_busy=1 sticky; then a pulse with rw=1 -> err_rw=1 and state unchanged.
REQ-039 SHALL include this scenario: reset asserted 10 cycles into BUSY after 0x01 -> all outputs at reset values immediately, and the next transfer after release is accepted.
